// File: rtl/de2_115_qsys_key_in_if.sv
// Avalon-MM slave bus bundle for the key input port.
// The CPU side drives address/strobes/data and the slave returns readdata.
interface de2_115_qsys_key_in_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/de2_115_qsys_key_in.sv
// DE2-115 key input PIO: two-flop synchronizer, per-bit debouncer,
// press-edge capture with write-1-to-clear, and a maskable level IRQ.
// Register map: 0 DATA (debounced), 1 DIRECTION (reads 0), 2 IRQMASK, 3 EDGECAPTURE.
module de2_115_qsys_key_in #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit IDLE_LEVEL      = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  de2_115_qsys_key_in_if.slave  bus,
  input  logic [WIDTH-1:0]      in_port,
  output logic                  irq
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [WIDTH-1:0]  IDLE_VEC = {WIDTH{IDLE_LEVEL}};
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_r;
  logic [WIDTH-1:0] sync2_r;
  logic [WIDTH-1:0] deb_r;
  logic [WIDTH-1:0] deb_prev_r;
  logic [CNT_W-1:0] cnt_r [WIDTH];
  logic [WIDTH-1:0] mask_r;
  logic [WIDTH-1:0] cap_r;
  logic             irq_r;

  logic             wr_en_s;
  logic [WIDTH-1:0] press_s;
  logic [WIDTH-1:0] clr_s;
  logic [WIDTH-1:0] mask_next_s;
  logic [WIDTH-1:0] cap_next_s;

  // Two-flop synchronizer; idles at the released level so reset looks like "no key".
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= IDLE_VEC;
      sync2_r <= IDLE_VEC;
    end else begin
      sync1_r <= in_port;
      sync2_r <= sync1_r;
    end
  end

  // Per-bit debouncer: the output follows only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_r <= IDLE_VEC;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2_r[i] == deb_r[i]) begin
          cnt_r[i] <= '0;
        end else if (cnt_r[i] == CNT_LAST) begin
          deb_r[i] <= sync2_r[i];
          cnt_r[i] <= '0;
        end else begin
          cnt_r[i] <= cnt_r[i] + 1'b1;
        end
      end
    end
  end

  // Delayed copy of the debounced value, used to spot the idle-to-active transition.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_prev_r <= IDLE_VEC;
    end else begin
      deb_prev_r <= deb_r;
    end
  end

  // Press pulse, bus write decode and next-state of mask and capture registers.
  always_comb begin
    press_s     = ~(deb_prev_r ^ IDLE_VEC) & (deb_r ^ IDLE_VEC);
    wr_en_s     = bus.chipselect & ~bus.write_n;
    mask_next_s = mask_r;
    clr_s       = '0;
    if (wr_en_s && (bus.address == 2'd2)) begin
      mask_next_s = bus.writedata[WIDTH-1:0];
    end else if (wr_en_s && (bus.address == 2'd3)) begin
      clr_s = bus.writedata[WIDTH-1:0];
    end else begin
      mask_next_s = mask_r;
    end
    // A press on the same edge as its clear keeps the bit set.
    cap_next_s = (cap_r & ~clr_s) | press_s;
  end

  // Mask, capture and IRQ registers; IRQ is computed from next-state so it tracks the registers exactly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_r <= '0;
      cap_r  <= '0;
      irq_r  <= 1'b0;
    end else begin
      mask_r <= mask_next_s;
      cap_r  <= cap_next_s;
      irq_r  <= |(cap_next_s & mask_next_s);
    end
  end

  assign irq = irq_r;

  // Zero-wait-state read mux; unused upper bits read as zero.
  always_comb begin
    bus.readdata = 32'd0;
    case (bus.address)
      2'd0:    bus.readdata[WIDTH-1:0] = deb_r;
      2'd1:    bus.readdata = 32'd0;
      2'd2:    bus.readdata[WIDTH-1:0] = mask_r;
      2'd3:    bus.readdata[WIDTH-1:0] = cap_r;
      default: bus.readdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_de2_115_qsys_key_in.sv
// Bench for de2_115_qsys_key_in: directed scenarios followed by random key/bus
// activity, all checked against a sliding-window behavioural model.
module tb_de2_115_qsys_key_in;
  localparam int W    = 4;
  localparam int D    = 4;
  localparam bit IDLE = 1'b1;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] in_port = 4'hF;
  logic         irq;

  de2_115_qsys_key_in_if bus();

  de2_115_qsys_key_in #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .IDLE_LEVEL(IDLE)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave),
    .in_port (in_port),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  logic [W-1:0] m_deb, m_cap, m_mask, m_press;
  logic         m_irq;
  logic [W-1:0] m_hist[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_deb   = {W{IDLE}};
    m_cap   = '0;
    m_mask  = '0;
    m_press = '0;
    m_irq   = 1'b0;
    m_hist  = {};
    for (int i = 0; i < D + 2; i++) m_hist.push_back({W{IDLE}});
  endtask

  // One clock edge of the model: the debounced bit flips once the last D
  // synchronizer outputs (raw delayed by two edges) all differ from it.
  task automatic model_edge(input logic [W-1:0] raw, input logic cs, input logic wn,
                            input logic [1:0] a, input logic [31:0] wd);
    logic [W-1:0] clr, new_deb, new_press, new_mask, new_cap;
    bit all_diff;
    int sz;
    clr = '0;
    new_mask = m_mask;
    if (cs && !wn && a == 2'd2) new_mask = wd[W-1:0];
    if (cs && !wn && a == 2'd3) clr = wd[W-1:0];
    new_cap = (m_cap & ~clr) | m_press;
    sz = m_hist.size();
    new_deb = m_deb;
    for (int b = 0; b < W; b++) begin
      all_diff = 1'b1;
      for (int j = 0; j < D; j++) begin
        if (m_hist[sz - 2 - j][b] == m_deb[b]) all_diff = 1'b0;
      end
      if (all_diff) new_deb[b] = ~m_deb[b];
    end
    for (int b = 0; b < W; b++) begin
      new_press[b] = (m_deb[b] == IDLE) && (new_deb[b] != IDLE);
    end
    m_hist.push_back(raw);
    if (m_hist.size() > 16) void'(m_hist.pop_front());
    m_deb   = new_deb;
    m_press = new_press;
    m_cap   = new_cap;
    m_mask  = new_mask;
    m_irq   = |(new_cap & new_mask);
  endtask

  task automatic tick();
    logic [W-1:0] li;
    logic lcs, lwn;
    logic [1:0] la;
    logic [31:0] lwd;
    li = in_port; lcs = bus.chipselect; lwn = bus.write_n;
    la = bus.address; lwd = bus.writedata;
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_edge(li, lcs, lwn, la, lwd);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.address = a;
    #1;
    d = bus.readdata;
  endtask

  task automatic check_model(input string tag);
    logic [1:0] sv;
    logic [31:0] d;
    sv = bus.address;
    rd(2'd0, d); chk({tag, "/data"}, d, {28'd0, m_deb});
    rd(2'd1, d); chk({tag, "/dir"},  d, 32'd0);
    rd(2'd2, d); chk({tag, "/mask"}, d, {28'd0, m_mask});
    rd(2'd3, d); chk({tag, "/edge"}, d, {28'd0, m_cap});
    bus.address = sv;
    chk({tag, "/irq"}, {31'd0, irq}, {31'd0, m_irq});
  endtask

  task automatic step(input string tag);
    tick();
    check_model(tag);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    tick();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    check_model("wr");
  endtask

  logic [31:0] r;

  initial begin
    bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 32'd0;
    model_reset();
    tick(); tick();
    reset_n = 1'b1;

    // 1. Reset values
    rd(2'd0, r); chk("rst_data", r, 32'h0000000F);
    rd(2'd1, r); chk("rst_dir",  r, 32'd0);
    rd(2'd2, r); chk("rst_mask", r, 32'd0);
    rd(2'd3, r); chk("rst_edge", r, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    check_model("rst");

    // 2. Clean press on bit 0
    in_port = 4'b1110;
    for (int e = 0; e <= 4; e++) step("press0");
    rd(2'd0, r); chk("press0_E4_data", r, 32'hF);
    step("press0");
    rd(2'd0, r); chk("press0_E5_data", r, 32'hE);
    rd(2'd3, r); chk("press0_E5_edge", r, 32'h0);
    step("press0");
    rd(2'd3, r); chk("press0_E6_edge", r, 32'h1);
    chk("press0_irq_masked", {31'd0, irq}, 32'd0);
    wr(2'd2, 32'h1);
    chk("mask_irq_rise", {31'd0, irq}, 32'd1);

    // Release bit 0: capture must stay as it was
    in_port = 4'hF;
    for (int e = 0; e < 10; e++) step("rel0");
    rd(2'd3, r); chk("rel0_edge", r, 32'h1);

    // 3. Bounce on bit 1: 3 low, 1 high, 3 low, then high
    for (int e = 0; e < 8; e++) begin
      in_port[1] = (e == 3 || e == 7) ? 1'b1 : 1'b0;
      step("bounce");
      rd(2'd0, r); chk("bounce_data", r, 32'hF);
    end
    for (int e = 0; e < 8; e++) step("bounce_tail");
    rd(2'd0, r); chk("bounce_data_end", r, 32'hF);
    rd(2'd3, r); chk("bounce_edge_end", r & 32'h2, 32'h0);

    // 4. Clear: build EDGECAPTURE=3 with mask=3
    in_port[1] = 1'b0;
    for (int e = 0; e < 8; e++) step("press1");
    rd(2'd3, r); chk("press1_edge", r, 32'h3);
    wr(2'd2, 32'h3);
    wr(2'd3, 32'h1);
    rd(2'd3, r); chk("clr1_edge", r, 32'h2);
    chk("clr1_irq", {31'd0, irq}, 32'd1);
    wr(2'd3, 32'h2);
    rd(2'd3, r); chk("clr2_edge", r, 32'h0);
    chk("clr2_irq", {31'd0, irq}, 32'd0);
    in_port = 4'hF;
    for (int e = 0; e < 10; e++) step("rel1");
    rd(2'd3, r); chk("rel1_edge", r, 32'h0);

    // 5. Collision: clear bit 2 on the edge where its press pulse sets it
    in_port[2] = 1'b0;
    for (int e = 0; e <= 5; e++) step("press2");
    bus.address = 2'd3; bus.writedata = 32'h4; bus.chipselect = 1'b1; bus.write_n = 1'b0;
    tick();
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
    check_model("collide");
    rd(2'd3, r); chk("collide_edge", r & 32'h4, 32'h4);
    in_port = 4'hF;
    for (int e = 0; e < 10; e++) step("rel2");

    // 6. Reset two cycles into a bit 3 press, key held through release
    in_port[3] = 1'b0;
    tick(); tick();
    reset_n = 1'b0;
    model_reset();
    #1;
    rd(2'd0, r); chk("rstmid_data", r, 32'hF);
    rd(2'd3, r); chk("rstmid_edge", r, 32'h0);
    chk("rstmid_irq", {31'd0, irq}, 32'd0);
    tick(); tick();
    reset_n = 1'b1;
    for (int e = 0; e <= 4; e++) step("held3");
    rd(2'd0, r); chk("held3_E4_data", r, 32'hF);
    step("held3");
    rd(2'd0, r); chk("held3_E5_data", r, 32'h7);
    step("held3");
    rd(2'd3, r); chk("held3_E6_edge", r, 32'h8);
    for (int e = 0; e < 6; e++) step("held3_hold");
    rd(2'd3, r); chk("held3_once", r, 32'h8);

    // 7. Random key activity and bus traffic against the model
    for (int c = 0; c < 500; c++) begin
      for (int b = 0; b < W; b++) begin
        if ($urandom_range(0, 7) == 0) in_port[b] = ~in_port[b];
      end
      if ($urandom_range(0, 5) == 0) begin
        bus.address = 2'($urandom_range(0, 3));
        bus.writedata = $urandom;
        bus.chipselect = 1'b1;
        bus.write_n = 1'b0;
      end else if ($urandom_range(0, 7) == 0) begin
        bus.address = 2'($urandom_range(0, 3));
        bus.writedata = $urandom;
        bus.chipselect = $urandom_range(0, 1) == 1;
        bus.write_n = ~bus.chipselect;
      end
      tick();
      bus.chipselect = 1'b0;
      bus.write_n = 1'b1;
      check_model("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
